axi_master_ctrl: RTL
====================

// Module: axi_master_ctrl
// PURPOSE
//  Command-driven AXI4 burst master directly upstream of axi_slave_* blocks: converts a simple
//  command (R/W, addr, len, burst) plus streamed write data into AW/W/B or AR/R transactions.
//  Returns read data as a stream, then one done pulse carrying the merged response.
//  One transaction outstanding at a time; no IDs on the write side, constant ARID on the read side.
// PARAMETERS
//  addr_wid_axi  32                  AXI address width
//  data_wid      32                  AXI data width (8/16/32/64/128)
//  asize         $clog2(data_wid/8)  width of awsize/arsize; value driven = log2(bytes/beat)
//  stroblen      data_wid/8          wstrb width
//  ARID_VAL      2'd0                constant driven on arid
// PORTS
//  aclk        in   1             clock; all logic on posedge
//  aresetn     in   1             asynchronous, active-low reset
//  cmd_valid   in   1             command request
//  cmd_ready   out  1             high only in IDLE
//  cmd_write   in   1             1=write, 0=read
//  cmd_addr    in   addr_wid_axi  burst start address
//  cmd_len     in   8             beats-1 (AXI len encoding)
//  cmd_burst   in   2             FIXED/INCR/WRAP, passed unchanged to AxBURST
//  wr_data     in   data_wid      write beat payload
//  wr_valid    in   1             write payload valid
//  wr_ready    out  1             = wready while in WR_DATA, else 0
//  rd_data     out  data_wid      = rdata
//  rd_valid    out  1             = rvalid while in RD_DATA, else 0
//  rd_last     out  1             high on the beat where beat counter == len
//  rd_ready    in   1             read payload consumer ready
//  done        out  1             one-cycle pulse at end of transaction
//  done_resp   out  2             merged response, valid only with done
//  len_err     out  1             rlast/counter mismatch seen, valid only with done
//  AXI master ports: awaddr awlen awsize awburst awvalid awready | wdata wstrb wlast wvalid wready |
//                    bresp bvalid bready | arid araddr arlen arsize arburst arvalid arready |
//                    rdata rresp rlast rvalid rready
//  Directions and widths exactly mirror the axi_slave_* port list.
// BEHAVIOUR
//  Reset (async, aresetn=0): state=IDLE; awvalid, wvalid, bready, arvalid, rready, done, len_err = 0;
//    done_resp=0; beat counter=0; latched cmd regs=0. Takes effect immediately, including mid-burst;
//    no done is issued for an aborted transaction.
//  FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
//  IDLE: cmd_valid & cmd_ready latches addr/len/burst/write; next state WR_ADDR or RD_ADDR.
//  WR_ADDR/RD_ADDR: AxVALID registered high on state entry and held until AxREADY.
//    AxADDR/AxLEN/AxBURST come from the latches; AxSIZE=asize value; transfer -> WR_DATA/RD_DATA.
//  WR_DATA: wvalid=wr_valid, wdata=wr_data, wstrb=all ones, wlast=(cnt==len).
//    Beat when wvalid&wready: cnt++. Beat with wlast -> WR_RESP, cnt=0.
//  WR_RESP: bready=1; on bvalid latch bresp -> DONE.
//  RD_DATA: rready=rd_ready. Beat when rvalid&rready: cnt++, resp_acc=max(resp_acc,rresp).
//    Beat with cnt==len -> DONE.
//  len_err set if (rlast & cnt!=len) or (!rlast & cnt==len) on any read beat.
//    Burst still completes on the counter, never on rlast alone.
//  DONE: done=1 for exactly one cycle; done_resp = bresp (write) or resp_acc (read); -> IDLE.
//    cmd_ready rises the cycle after done.
//  AXI rules: a VALID, once asserted, is never dropped or changed before its READY. No VALID
//    depends combinationally on its READY; wvalid follows wr_valid only, which the producer must
//    itself hold stable.
//  Length/arithmetic: cnt is 8 bits, wraps never (max len=255 ends burst). len=0 is a
//    single-beat burst with wlast/rd_last on beat 0. Master does not split 4KB crossings or check
//    WRAP alignment.
//  Simultaneous events: AxREADY already high in the AxVALID cycle -> transfer in that cycle,
//    no extra wait. cmd_valid during DONE is ignored (cmd_ready=0).
// STRUCTURE
//  axi_pkg: typedef enum burst_t {FIXED,INCR,WRAP}; resp_t {OKAY,EXOKAY,SLVERR,DECERR};
//    mst_state_t; shared by master, interconnect and slaves.
//  Single flat module; the beat counter/last logic is too small to warrant a sub-module.
//  Optional future split: axi_mst_rd / axi_mst_wr engines behind a shared command front end.
// TESTING
//  1. Write addr=0x100, len=3, INCR, data 0xA0..0xA3, zero-wait slave, bresp=OKAY
//     -> 4 W beats, wlast only on 0xA3, done with resp=0.
//  2. Read addr=0x200, len=0, rresp=OKAY, rlast=1 -> one rd_valid beat, rd_last=1,
//     done with resp=0 and len_err=0.
//  3. Read len=7 with rresp=SLVERR on beat 4 and random rvalid/rd_ready stalls
//     -> 8 beats in order, done_resp=2'b10.
//  4. awready held low for 5 cycles -> awvalid and awaddr stable all 5 cycles;
//     wvalid stays 0 until the AW transfer.
//  5. Read len=3, slave asserts rlast on beat 1 -> burst runs 4 beats, done with len_err=1.
//  6. aresetn low during beat 2 of a len=5 write -> all VALIDs 0 asynchronously, no done;
//     after release a new read command completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI types for the master, interconnect and slaves.
package axi_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned RESP_W = 2;

  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;

  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } mst_state_t;

  // Worst-of merge: higher encoding is the more severe response.
  function automatic logic [RESP_W-1:0] resp_max(input logic [RESP_W-1:0] a,
                                                 input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_master_ctrl.sv
// Command-driven AXI4 burst master: one write (AW/W/B) or read (AR/R) burst outstanding,
// streamed payload on both sides, one done pulse carrying the merged response.
module axi_master_ctrl
  import axi_pkg::*;
#(
  parameter int unsigned addr_wid_axi = 32,
  parameter int unsigned data_wid     = 32,
  parameter int unsigned asize        = $clog2(data_wid / 8),
  parameter int unsigned stroblen     = data_wid / 8,
  parameter logic [1:0]  ARID_VAL     = 2'd0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // command / stream side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [addr_wid_axi-1:0] cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [1:0]              cmd_burst,
  input  logic [data_wid-1:0]     wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [data_wid-1:0]     rd_data,
  output logic                    rd_valid,
  output logic                    rd_last,
  input  logic                    rd_ready,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    len_err,
  // AXI write address
  output logic [addr_wid_axi-1:0] awaddr,
  output logic [7:0]              awlen,
  output logic [asize-1:0]        awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI write data / response
  output logic [data_wid-1:0]     wdata,
  output logic [stroblen-1:0]     wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI read address
  output logic [1:0]              arid,
  output logic [addr_wid_axi-1:0] araddr,
  output logic [7:0]              arlen,
  output logic [asize-1:0]        arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI read data
  input  logic [data_wid-1:0]     rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam logic [asize-1:0] SIZE_VAL = asize[asize-1:0];

  mst_state_t              state;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_q;
  logic [addr_wid_axi-1:0] addr_q;
  logic [1:0]              burst_q;
  logic [RESP_W-1:0]       resp_acc;
  logic                    err_acc;

  logic              at_last_c;
  logic              wr_beat_c;
  logic              rd_beat_c;
  logic [RESP_W-1:0] resp_nxt_c;
  logic              err_nxt_c;

  // Stream-side handshakes pass straight through, qualified by the data states.
  assign cmd_ready = (state == IDLE);
  assign wvalid    = (state == WR_DATA) && wr_valid;
  assign wr_ready  = (state == WR_DATA) && wready;
  assign wdata     = wr_data;
  assign wstrb     = {stroblen{1'b1}};
  assign wlast     = (state == WR_DATA) && at_last_c;
  assign rready    = (state == RD_DATA) && rd_ready;
  assign rd_valid  = (state == RD_DATA) && rvalid;
  assign rd_data   = rdata;
  assign rd_last   = (state == RD_DATA) && at_last_c;

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = SIZE_VAL;
  assign awburst = burst_q;
  assign arid    = ARID_VAL;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = SIZE_VAL;
  assign arburst = burst_q;

  assign at_last_c  = (cnt == len_q);
  assign wr_beat_c  = wvalid && wready;
  assign rd_beat_c  = rvalid && rready;
  assign resp_nxt_c = resp_max(resp_acc, rresp);
  // The counter owns burst end; rlast only feeds the length-error flag.
  assign err_nxt_c  = err_acc || (rlast != at_last_c);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      resp_acc  <= '0;
      err_acc   <= 1'b0;
      awvalid   <= 1'b0;
      arvalid   <= 1'b0;
      bready    <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
      len_err   <= 1'b0;
    end else begin
      done      <= 1'b0;
      done_resp <= '0;
      len_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            burst_q  <= cmd_burst;
            cnt      <= '0;
            resp_acc <= '0;
            err_acc  <= 1'b0;
            if (cmd_write) begin
              awvalid <= 1'b1;
              state   <= WR_ADDR;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (wr_beat_c) begin
            if (at_last_c) begin
              cnt    <= '0;
              bready <= 1'b1;
              state  <= WR_RESP;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            done      <= 1'b1;
            done_resp <= bresp;
            state     <= DONE;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rd_beat_c) begin
            resp_acc <= resp_nxt_c;
            err_acc  <= err_nxt_c;
            if (at_last_c) begin
              cnt       <= '0;
              done      <= 1'b1;
              done_resp <= resp_nxt_c;
              len_err   <= err_nxt_c;
              state     <= DONE;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
